// File: rtl/balsa_hs_pkg.sv
// Shared definitions for clocked Balsa handshake components.
//   pull_state_t : out-channel FSM states of the pull-combine block
//   hs_phase_t   : phase of a single 4-phase initiator cycle
//   DEF_*        : default part width and part count
package balsa_hs_pkg;

  localparam int DEF_IN_WIDTH = 9;
  localparam int DEF_PARTS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREQ,
    ST_PRTZ,
    ST_OACK,
    ST_ORTZ
  } pull_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_REQ,
    PH_RTZ
  } hs_phase_t;

endpackage

// File: rtl/balsa_hs_initiator.sv
// One 4-phase initiator cycle: raise req on start, drop it once ack is seen,
// then wait for ack to return to zero.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a cycle (honoured in idle, or in RTZ as ack falls)
//   ack        : acknowledge from the responder
//   req        : registered request to the responder
//   capture    : strobe, high on the edge where ack is first seen high
//   done       : strobe, high on the edge where ack is seen back at zero
module balsa_hs_initiator
  import balsa_hs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic capture,
  output logic done
);

  hs_phase_t phase;

  // Strobes are combinational so the parent can act on the same edge that
  // moves this handshake on; that keeps one cycle per handshake phase.
  assign capture = (phase == PH_REQ) && ack;
  assign done    = (phase == PH_RTZ) && !ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      req   <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            phase <= PH_REQ;
            req   <= 1'b1;
          end
        end
        PH_REQ: begin
          if (ack) begin
            phase <= PH_RTZ;
            req   <= 1'b0;
          end
        end
        PH_RTZ: begin
          if (!ack) begin
            // Chaining straight into the next cycle avoids an idle bubble.
            if (start) begin
              phase <= PH_REQ;
              req   <= 1'b1;
            end else begin
              phase <= PH_IDLE;
            end
          end
        end
        default: begin
          phase <= PH_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/balsa_pull_combine.sv
// Pull-combine: on one pull from the consumer, pulls PARTS parts from the
// producer and returns them concatenated, part 0 in the least-significant bits.
//   clk, rst_n : clock, async active-low reset
//   out_0r/0a/0d : responder side (consumer pulls the combined word)
//   inp_0r/0a/0d : initiator side (this block pulls each part)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for out_0r
// PREQ    | inp_0r high, waiting for inp_0a to capture part cnt
// PRTZ    | inp_0r low, waiting for inp_0a to return to zero
// OACK    | word complete, out_0a high until out_0r is seen low
// ORTZ    | one-cycle gap after out_0a falls, then IDLE
module balsa_pull_combine
  import balsa_hs_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int PARTS     = DEF_PARTS,
  localparam int OUT_WIDTH = IN_WIDTH * PARTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 out_0r,
  output logic                 out_0a,
  output logic [OUT_WIDTH-1:0] out_0d,
  output logic                 inp_0r,
  input  logic                 inp_0a,
  input  logic [IN_WIDTH-1:0]  inp_0d
);

  localparam int CW = $clog2(PARTS);
  localparam logic [CW-1:0] LAST_PART = CW'(PARTS - 1);

  pull_state_t   state;
  logic [CW-1:0] cnt;
  logic          hs_start;
  logic          hs_capture;
  logic          hs_done;

  // Start a part pull when a consumer request is accepted, or when the
  // previous part has fully returned to zero and more parts remain.
  assign hs_start = ((state == ST_IDLE) && out_0r) ||
                    ((state == ST_PRTZ) && hs_done && (cnt != LAST_PART));

  balsa_hs_initiator u_init (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (hs_start),
    .ack     (inp_0a),
    .req     (inp_0r),
    .capture (hs_capture),
    .done    (hs_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      out_0a <= 1'b0;
      out_0d <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (out_0r) begin
            state <= ST_PREQ;
            cnt   <= '0;
          end
        end
        ST_PREQ: begin
          if (hs_capture) begin
            for (int p = 0; p < PARTS; p++) begin
              if (cnt == CW'(p)) out_0d[p*IN_WIDTH +: IN_WIDTH] <= inp_0d;
            end
            state <= ST_PRTZ;
          end
        end
        ST_PRTZ: begin
          if (hs_done) begin
            if (cnt != LAST_PART) begin
              cnt   <= cnt + CW'(1);
              state <= ST_PREQ;
            end else begin
              state  <= ST_OACK;
              out_0a <= 1'b1;
            end
          end
        end
        ST_OACK: begin
          // An early-dropped out_0r lands here too: ack for one cycle only.
          if (!out_0r) begin
            out_0a <= 1'b0;
            state  <= ST_ORTZ;
          end
        end
        ST_ORTZ: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          out_0a <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_balsa_pull_combine.sv
// Scoreboard bench for balsa_pull_combine: a default instance (9-bit x 2) and a
// 4-bit x 4 instance. Producers answer each inp_0r phase after a programmable
// number of negedges; expected words and latencies are queued at issue time and
// checked by monitors when out_0a rises.
module tb_balsa_pull_combine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_0r, out_0a, inp_0r, inp_0a;
  logic [17:0] out_0d;
  logic [8:0]  inp_0d;
  logic        o4_r, o4_a, i4_r, i4_a;
  logic [15:0] o4_d;
  logic [3:0]  i4_d;

  typedef struct {
    logic [63:0] word;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  logic [8:0]  parts_q[$];
  logic [3:0]  parts4_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          delay = 1;
  int          wcnt = 0;
  int          wcnt4 = 0;
  bit          hold = 0;
  logic [63:0] last_word = 0;

  balsa_pull_combine dut (
    .clk(clk), .rst_n(rst_n), .out_0r(out_0r), .out_0a(out_0a), .out_0d(out_0d),
    .inp_0r(inp_0r), .inp_0a(inp_0a), .inp_0d(inp_0d)
  );

  balsa_pull_combine #(.IN_WIDTH(4), .PARTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .out_0r(o4_r), .out_0a(o4_a), .out_0d(o4_d),
    .inp_0r(i4_r), .inp_0a(i4_a), .inp_0d(i4_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] req);
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) fail(nm, act, req);
  endtask

  // Producers: mirror inp_0r onto inp_0a once it has differed for more than
  // 'delay' negedges; a rising ack presents the next queued part.
  always @(negedge clk) begin
    if (!rst_n || hold) begin
      wcnt = 0;
    end else if (inp_0r != inp_0a) begin
      wcnt++;
      if (wcnt > delay) begin
        wcnt = 0;
        if (inp_0r) begin
          if (parts_q.size() > 0) begin
            inp_0d = parts_q.pop_front();
          end else begin
            inp_0d = 9'h0;
            fail("unexpected_pull", 64'(inp_0r), 64'(0));
          end
        end else begin
          inp_0d = 9'($urandom);
        end
        inp_0a = inp_0r;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt4 = 0;
    end else if (i4_r != i4_a) begin
      wcnt4++;
      if (wcnt4 > 1) begin
        wcnt4 = 0;
        if (i4_r) begin
          if (parts4_q.size() > 0) begin
            i4_d = parts4_q.pop_front();
          end else begin
            i4_d = 4'h0;
            fail("unexpected_pull4", 64'(i4_r), 64'(0));
          end
        end else begin
          i4_d = 4'($urandom);
        end
        i4_a = i4_r;
      end
    end else begin
      wcnt4 = 0;
    end
  end

  // Monitor for the default instance, sampled 1 time unit after each edge.
  logic        prev_r = 0, prev_oa = 0;
  logic [17:0] held = 0;
  exp_t        me;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_r  = 0;
      prev_oa = 0;
    end else begin
      chk("no_overlap", 64'(inp_0r & out_0a), 64'(0));
      if (inp_0r && !prev_r) chk("req_rise_with_ack_low", 64'(inp_0a), 64'(0));
      if (!inp_0r && prev_r) chk("req_fall_with_ack_high", 64'(inp_0a), 64'(1));
      if (out_0a && !prev_oa) begin
        if (exp_q.size() == 0) begin
          chk("ack_expected", 64'(0), 64'(1));
        end else begin
          me = exp_q.pop_front();
          chk("word", 64'(out_0d), me.word);
          if (me.lat >= 0) chk("latency", 64'(cyc - me.t0), 64'(me.lat));
          held = out_0d;
        end
      end else if (prev_oa) begin
        chk("word_stable", 64'(out_0d), 64'(held));
      end
      prev_r  = inp_0r;
      prev_oa = out_0a;
    end
  end

  logic prev4_a = 0;
  exp_t me4;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev4_a = 0;
    end else begin
      chk("no_overlap4", 64'(i4_r & o4_a), 64'(0));
      if (o4_a && !prev4_a) begin
        if (exp4_q.size() == 0) begin
          chk("ack4_expected", 64'(0), 64'(1));
        end else begin
          me4 = exp4_q.pop_front();
          chk("word4", 64'(o4_d), me4.word);
          chk("latency4", 64'(cyc - me4.t0), 64'(me4.lat));
        end
      end
      prev4_a = o4_a;
    end
  end

  // Reference model: word = sum of part_i << (i*width); with a producer that
  // answers after d+1 edges per phase, each part costs 2*(d+1) edges, plus
  // the edge that samples out_0r.
  task automatic issue(input logic [8:0] p0, input logic [8:0] p1, input int d, input bit lat_en);
    exp_t e;
    delay = d;
    parts_q.push_back(p0);
    parts_q.push_back(p1);
    e.word = 64'(p0) | (64'(p1) << 9);
    e.t0   = cyc;
    e.lat  = lat_en ? 1 + 2 * (d + 1) * 2 : -1;
    exp_q.push_back(e);
    last_word = e.word;
    out_0r = 1'b1;
  endtask

  task automatic wait_oa(input logic lvl, input string nm);
    int n = 0;
    while (out_0a !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(out_0a), 64'(lvl));
  endtask

  task automatic wait_ir(input logic lvl, input string nm);
    int n = 0;
    while (inp_0r !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(inp_0r), 64'(lvl));
  endtask

  task automatic finish_txn();
    @(negedge clk);
    wait_oa(1'b1, "ack_rise");
    out_0r = 1'b0;
    wait_oa(1'b0, "ack_fall");
  endtask

  task automatic txn(input logic [8:0] p0, input logic [8:0] p1, input int d);
    issue(p0, p1, d, 1'b1);
    finish_txn();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_c;
    exp_t e4;
    logic [63:0] w4;
    logic [3:0] p4;
    rst_n = 1'b0; out_0r = 1'b0; inp_0a = 1'b0; inp_0d = '0;
    o4_r = 1'b0; i4_a = 1'b0; i4_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_0a", 64'(out_0a), 64'(0));
    chk("rst_inp_0r", 64'(inp_0r), 64'(0));
    chk("rst_out_0d", 64'(out_0d), 64'(0));
    chk("rst_o4_d", 64'(o4_d), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pull with a zero-wait producer: 0x1A5, 0x05A -> 0x0B5A5, latency 9.
    txn(9'h1A5, 9'h05A, 1);
    // Slow producer.
    txn(9'($urandom), 9'($urandom), 5);

    // Ack glitches while idle must not be captured.
    hold = 1;
    inp_0d = 9'h1FF;
    repeat (3) begin
      inp_0a = 1'b1; @(negedge clk);
      inp_0a = 1'b0; @(negedge clk);
    end
    chk("idle_word_kept", 64'(out_0d), last_word);
    chk("idle_no_req", 64'(inp_0r), 64'(0));
    hold = 0;

    // Back-to-back: re-raise out_0r in the cycle out_0a falls.
    issue(9'($urandom), 9'($urandom), 1, 1'b1);
    finish_txn();
    fall_c = cyc;
    issue(9'($urandom), 9'($urandom), 1, 1'b0);
    wait_ir(1'b1, "b2b_req");
    checks++;
    if (cyc - fall_c < 2) fail("b2b_gap", 64'(cyc - fall_c), 64'(2));
    @(negedge clk);
    wait_oa(1'b1, "b2b_ack_rise");
    out_0r = 1'b0;
    wait_oa(1'b0, "b2b_ack_fall");
    @(negedge clk);

    // Early drop of out_0r after the first part.
    issue(9'($urandom), 9'($urandom), 1, 1'b1);
    wait_ir(1'b1, "early_req0");
    wait_ir(1'b0, "early_req0_low");
    out_0r = 1'b0;
    wait_oa(1'b1, "early_ack");
    @(negedge clk);
    chk("early_ack_one_cycle", 64'(out_0a), 64'(0));
    repeat (2) @(negedge clk);
    chk("early_idle_no_req", 64'(inp_0r), 64'(0));

    // Reset pulse during the return-to-zero of part 0.
    issue(9'h0F3, 9'h13C, 1, 1'b0);
    wait_ir(1'b1, "rst_req0");
    wait_ir(1'b0, "rst_req0_low");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_0a", 64'(out_0a), 64'(0));
    chk("async_rst_inp_0r", 64'(inp_0r), 64'(0));
    chk("async_rst_out_0d", 64'(out_0d), 64'(0));
    exp_q.delete();
    parts_q.delete();
    inp_0a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(9'($urandom), 9'($urandom), 1, 1'b0);
    finish_txn();
    @(negedge clk);

    // Randomized transactions.
    for (int i = 0; i < 8; i++) txn(9'($urandom), 9'($urandom), int'($urandom_range(1, 3)));

    // Four-part instance: 0x1,0x2,0x3,0x4 -> 0x4321, then a random word.
    for (int t = 0; t < 2; t++) begin
      w4 = 0;
      for (int i = 0; i < 4; i++) begin
        p4 = (t == 0) ? 4'(i + 1) : 4'($urandom);
        parts4_q.push_back(p4);
        w4 = w4 | (64'(p4) << (4 * i));
      end
      e4.word = w4;
      e4.t0   = cyc;
      e4.lat  = 1 + 4 * 4;
      exp4_q.push_back(e4);
      o4_r = 1'b1;
      for (int n = 0; n < 400 && o4_a !== 1'b1; n++) @(negedge clk);
      chk("ack4_rise", 64'(o4_a), 64'(1));
      o4_r = 1'b0;
      for (int n = 0; n < 400 && o4_a !== 1'b0; n++) @(negedge clk);
      chk("ack4_fall", 64'(o4_a), 64'(0));
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size() + exp4_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/balsa_pull_combine.md
BALSA_PULL_COMBINE -- requirements
Module: balsa_pull_combine

Interface
REQ-001 Parameter IN_WIDTH, default 9: width of one part pulled on the inp channel.
REQ-002 Parameter PARTS, default 2: number of parts combined into one output word; range 2..8.
REQ-003 Derived width OUT_WIDTH = IN_WIDTH*PARTS, default 18.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 out_0r  input  1  pull request from the consumer, 4-phase.
REQ-008 out_0a  output  1  acknowledge to the consumer; data valid while high.
REQ-009 out_0d  output  OUT_WIDTH  combined word.
REQ-010 inp_0r  output  1  pull request to the producer, 4-phase.
REQ-011 inp_0a  input  1  acknowledge from the producer.
REQ-012 inp_0d  input  IN_WIDTH  part data; sampled only while inp_0a is high.

Function
REQ-013 The block SHALL act as responder on the out channel and initiator on the inp channel. All inputs are synchronous to clk.
REQ-014 FSM states: IDLE, PREQ, PRTZ, OACK, ORTZ.
- Part counter cnt: clog2(PARTS) bits.
- All outputs are registered.
REQ-015 IDLE: if out_0r=1 at an edge, go to PREQ with cnt=0 and inp_0r=1 from the next cycle.
REQ-016 PREQ: if inp_0a=1 at an edge:
- capture inp_0d into out_0d bits [cnt*IN_WIDTH +: IN_WIDTH];
- go to PRTZ with inp_0r=0.
REQ-017 PRTZ: if inp_0a=0 at an edge:
- if cnt<PARTS-1: increment cnt, go to PREQ, inp_0r=1;
- else go to OACK with out_0a=1.
REQ-018 Part 0 SHALL occupy the least-significant bits; part PARTS-1 the most-significant.
REQ-019 OACK: out_0a SHALL remain 1 until out_0r=0 is sampled; then out_0a=0 and go to ORTZ.
REQ-020 ORTZ lasts exactly one cycle and returns to IDLE, so a new request is never accepted in the same cycle out_0a falls.
REQ-021 out_0d SHALL be stable from the last capture through the cycle out_0a falls, and holds its value until overwritten by the next transaction.
REQ-022 Latency with a zero-wait producer (inp_0a responding one cycle after inp_0r): out_0a rises 1 + 4*PARTS cycles after out_0r is sampled high, i.e. 9 cycles for PARTS=2.
REQ-023 out_0r falling before out_0a rises is a protocol violation. The block SHALL ignore it, complete all pulls, and assert out_0a. The consumer then sees RTZ immediately.
REQ-024 inp_0a changes outside PREQ/PRTZ SHALL be ignored, with no capture.
REQ-025 inp_0r and out_0a SHALL never both be 1.

Reset
REQ-026 Reset assertion at any time, including mid-transaction, SHALL immediately force:
- state=IDLE, cnt=0;
- inp_0r=0, out_0a=0, out_0d=0.
REQ-027 After reset release, the first transaction SHALL start only on out_0r sampled high. A partially collected word is discarded.

Structure
REQ-028 A shared package balsa_hs_pkg SHALL hold:
- the FSM state enum;
- a 4-phase phase-encoding typedef;
- the default IN_WIDTH/PARTS constants.
REQ-029 One sub-module, balsa_hs_initiator, SHALL implement a single 4-phase initiator cycle (start, done, capture strobe), reusable by other clocked Balsa components. The top-level SHALL hold cnt, the word register, and the out-channel FSM.

Verification
REQ-030 Basic pull, zero-wait producer, PARTS=2, IN_WIDTH=9: parts 0x1A5 then 0x05A -> out_0d=0x0B5A5, out_0a high at cycle 9 after out_0r.
REQ-031 Slow producer, inp_0a delayed 5 cycles per phase -> out_0d correct, inp_0r/inp_0a sequence legal 4-phase, out_0a never overlaps inp_0r.
REQ-032 Back-to-back transactions, out_0r re-raised the cycle after out_0a falls -> first inp_0r of the second transaction is not earlier than 2 cycles after out_0a falls; both words correct.
REQ-033 rst_n pulsed low during PRTZ of part 0 -> all outputs 0 asynchronously; after release with out_0r=1, a fresh 2-part collection yields the correct new word.
REQ-034 out_0r dropped after first part (violation) -> second part still pulled, out_0a rises for 1 cycle, then ORTZ, then IDLE.
REQ-035 PARTS=4, IN_WIDTH=4, parts 0x1,0x2,0x3,0x4 -> out_0d=0x4321.
